rr_mux_arb: RTL
===============

RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (>=1).
REQ-002 Parameter NCH, default 3, number of input channels (>=2).
REQ-003 Parameter SELW, default $clog2(NCH), width of sel and out_chan (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-007 sel  input  SELW  channel index used when mode = 0.
REQ-008 in_data  input  NCH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NCH  per-channel request/valid.
REQ-010 in_ready  output  NCH  per-channel accept strobe (combinational).
REQ-011 outp  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  outp holds an unconsumed word.
REQ-013 out_chan  output  SELW  index of the channel that supplied outp.
REQ-014 out_ready  input  1  downstream accepts outp when high with out_valid.

Function
REQ-015 load = (!out_valid || out_ready) && (a channel is granted); at most one in_ready bit is high, and only when load is high.
REQ-016 Mode 0: granted channel = sel if sel < NCH and in_valid[sel] = 1; otherwise no grant.
REQ-017 Mode 1: granted channel = first i with in_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NCH (wrap-around).
REQ-018 On load with grant k: outp <= channel k data, out_chan <= k, out_valid <= 1, next cycle (latency 1).
REQ-019 On load in mode 1: rr_ptr <= (k+1) mod NCH; k = NCH-1 wraps rr_ptr to 0.
REQ-020 rr_ptr unchanged in mode 0 and on cycles without load.
REQ-021 out_valid && out_ready with no new grant: out_valid <= 0; outp and out_chan hold their last value.
REQ-022 out_valid && out_ready with a new grant in the same cycle: outp is replaced back-to-back; out_valid stays 1 (full throughput).
REQ-023 out_valid && !out_ready: outp, out_chan and out_valid stable; in_ready = 0.
REQ-024 mode or sel changes take effect on the next arbitration decision; a held outp is never altered.
REQ-025 in_valid dropping without in_ready: no transfer, no state change.

Reset
REQ-026 rst high, asynchronously: out_valid = 0, outp = 0, out_chan = 0, rr_ptr = 0.
REQ-027 in_ready = 0 while rst is high.
REQ-028 Reset asserted mid-transfer discards the held word; no partial word is delivered after release.
REQ-029 First arbitration after reset in mode 1 starts at channel 0.

Structure
REQ-030 Shared package holds: mode encoding constants (MODE_FIXED = 0, MODE_RR = 1), default WIDTH = 32, default NCH = 3.
REQ-031 Round-robin grant logic is one sub-module, rr_arbiter (inputs: req, ptr; outputs: grant_valid, grant_idx).
REQ-032 Data path is a parametrised NCH:1 select of WIDTH bits followed by one output register; no storage beyond one word.

Verification (WIDTH = 32, NCH = 3)
REQ-033 mode = 0, sel = 1, in_valid = 3'b010, ch1 = 32'h5555, out_ready = 1 -> in_ready = 3'b010; next cycle outp = 32'h5555, out_chan = 1, out_valid = 1.
REQ-034 mode = 1, in_valid = 3'b111 held, out_ready = 1, ch0/1/2 = 32'haaaa/32'h5555/32'h7777 -> out_chan sequence 0,1,2,0 on consecutive cycles; rr_ptr wraps to 0.
REQ-035 out_valid = 1, out_ready = 0 for 4 cycles -> outp stable, in_ready = 0 throughout; out_ready = 1 -> next word loads the same cycle.
REQ-036 mode = 0, sel = 3 (out of range), in_valid = 3'b111 -> in_ready = 0, out_valid falls to 0 after drain.
REQ-037 rst pulsed while out_valid = 1, out_ready = 0 -> out_valid = 0 and outp = 0 immediately, without waiting for a clk edge; after release in mode 1 with in_valid = 3'b110, grant = channel 1.
REQ-038 mode 1 with in_valid = 3'b101 and rr_ptr = 1 -> grant channel 2, then channel 0 (wrap), then channel 2.

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// Shared constants for the round-robin / fixed-select channel multiplexer.
package rr_mux_arb_pkg;

  // Arbitration mode encoding carried on the mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Default geometry of the multiplexer
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 3;

endpackage

// File: rtl/rr_mux_arb_arbiter.sv
// Round-robin grant search: first requesting channel at or after ptr, with
// wrap-around modulo NCH. Purely combinational.
module rr_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(ptr) + i) % NCH;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// NCH:1 data multiplexer with fixed-select or round-robin arbitration and a
// single registered output word using a valid/ready handshake.
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     outp,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic             rr_valid;
  logic [SELW-1:0]  rr_idx;
  logic             grant_valid_p0;
  logic [SELW-1:0]  grant_idx_p0;
  logic             load_p0;
  logic [WIDTH-1:0] data_p0;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  // Pick the grant source; an out-of-range sel never grants
  always_comb begin
    grant_valid_p0 = 1'b0;
    grant_idx_p0   = '0;
    if (mode == MODE_RR) begin
      grant_valid_p0 = rr_valid;
      grant_idx_p0   = rr_idx;
    end else if (int'(sel) < NCH) begin
      if (in_valid[sel]) begin
        grant_valid_p0 = 1'b1;
        grant_idx_p0   = sel;
      end
    end
  end

  // Accept when the output slot is free or being drained this cycle
  always_comb begin
    load_p0  = (!out_valid || out_ready) && grant_valid_p0 && !rst;
    data_p0  = in_data[int'(grant_idx_p0)*WIDTH +: WIDTH];
    in_ready = '0;
    if (load_p0) in_ready[grant_idx_p0] = 1'b1;
  end

  // ---- stage p0 -> output register ----
  // Output word, its source channel, and the round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outp      <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (load_p0) begin
      outp      <= data_p0;
      out_chan  <= grant_idx_p0;
      out_valid <= 1'b1;
      if (mode == MODE_RR)
        rr_ptr <= (grant_idx_p0 == SELW'(NCH - 1)) ? '0 : grant_idx_p0 + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
